// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite subordinate serving one word-organised SRAM region.
// Optional wait states (WAIT parameter) are built only when AHB_SRAM_WAIT_EN is defined.
module ahb_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          WAIT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;

`ifdef AHB_SRAM_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`endif

  state_t          state, state_nx;
  logic            open_slot, accept, illegal;
  logic [3:0]      be_nx, be_q;
  logic [IW-1:0]   idx_q;
  logic            wr_q;
  logic            do_write;
  logic [31:0]     mem [DEPTH];

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0]      wcnt, wcnt_nx;
`endif

  // htrans[0] only separates BUSY/SEQ from IDLE/NONSEQ, which this slave treats alike
  logic unused_cfg;
  assign unused_cfg = ^{htrans[0], 32'(WAIT)};

  // A new address phase can only be taken while the current data phase is finishing
  assign open_slot = (state == S_IDLE) | (state == S_DATA) | (state == S_ERR2);
  assign accept    = open_slot & hsel & hready & htrans[1];

  always_comb begin
    illegal = 1'b0;
    if (hsize > 3'd2)                              illegal = 1'b1;
    if (hsize == 3'd1 && haddr[0])                 illegal = 1'b1;
    if (hsize == 3'd2 && haddr[1:0] != 2'b00)      illegal = 1'b1;
    if (haddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W])  illegal = 1'b1;
  end

  always_comb begin
    be_nx = 4'b0000;
    case (hsize)
      3'd0:    be_nx = 4'b0001 << haddr[1:0];
      3'd1:    be_nx = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_nx = 4'b1111;
    endcase
  end

  always_comb begin
    state_nx  = state;
    hreadyout = 1'b1;
    hresp     = 1'b0;
`ifdef AHB_SRAM_WAIT_EN
    wcnt_nx   = wcnt;
`endif
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        hresp    = (state == S_ERR2);
        state_nx = S_IDLE;
        if (accept) begin
          if (illegal)
            state_nx = S_ERR1;
`ifdef AHB_SRAM_WAIT_EN
          else if (WAIT_CNT != 4'd0) begin
            state_nx = S_WAIT;
            wcnt_nx  = WAIT_CNT;
          end
`endif
          else
            state_nx = S_DATA;
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      S_WAIT: begin
        hreadyout = 1'b0;
        wcnt_nx   = wcnt - 4'd1;
        if (wcnt == 4'd1) state_nx = S_DATA;
      end
`endif
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nx  = S_ERR2;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx_q <= '0;
      be_q  <= '0;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        idx_q <= haddr[ADDR_W-1:2];
        be_q  <= be_nx;
        wr_q  <= hwrite;
      end
    end
  end

`ifdef AHB_SRAM_WAIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 4'd0;
    else      wcnt <= wcnt_nx;
  end
`endif

  // Async reset drops state out of DATA, so an abandoned write never lands
  assign do_write = (state == S_DATA) & wr_q;

  always_ff @(posedge clk) begin
    if (do_write)
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
  end

  // Read port sees the previous cycle's write, giving back-to-back read-after-write
  assign hrdata = (state == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;

endmodule
